// File: rtl/if_stage_pkg.sv
// Shared constants, types and the fetch-address check for the P7 fetch stage.
package if_stage_pkg;

  localparam logic [31:0] PC_RESET_DEF  = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY_DEF = 32'h0000_4180;
  localparam logic [31:0] IM_BASE_DEF   = 32'h0000_3000;
  localparam logic [31:0] IM_LIMIT_DEF  = 32'h0000_6FFC;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  typedef enum logic [1:0] {
    IFID_LOAD   = 2'd0,
    IFID_HOLD   = 2'd1,
    IFID_BUBBLE = 2'd2
  } ifid_ctrl_e;

  // Address error on fetch: misaligned or outside the instruction window (unsigned).
  function automatic logic fetch_addr_err(input logic [31:0] pc,
                                          input logic [31:0] base,
                                          input logic [31:0] limit);
    return (pc[1:0] != 2'b00) || (pc < base) || (pc > limit);
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  ifid_ctrl_e  ctrl,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc8_in,
  input  logic [4:0]  exc_in,
  input  logic        bd_in,
  input  logic [31:0] bubble_pc,
  input  logic [31:0] bubble_pc8,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic [4:0]  exc_d,
  output logic        bd_d
);

  // Bubbles carry a caller-chosen PC so an interrupt on the bubble still has an EPC.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_d <= 32'h0000_0000;
      pc_d    <= 32'h0000_0000;
      pc8_d   <= 32'h0000_0000;
      exc_d   <= EXC_NONE;
      bd_d    <= 1'b0;
    end else begin
      case (ctrl)
        IFID_LOAD: begin
          instr_d <= instr_in;
          pc_d    <= pc_in;
          pc8_d   <= pc8_in;
          exc_d   <= exc_in;
          bd_d    <= bd_in;
        end
        IFID_BUBBLE: begin
          instr_d <= 32'h0000_0000;
          pc_d    <= bubble_pc;
          pc8_d   <= bubble_pc8;
          exc_d   <= EXC_NONE;
          bd_d    <= 1'b0;
        end
        IFID_HOLD: begin
          instr_d <= instr_d;
          pc_d    <= pc_d;
          pc8_d   <= pc8_d;
          exc_d   <= exc_d;
          bd_d    <= bd_d;
        end
        default: begin
          instr_d <= instr_d;
          pc_d    <= pc_d;
          pc8_d   <= pc8_d;
          exc_d   <= exc_d;
          bd_d    <= bd_d;
        end
      endcase
    end
  end

endmodule

// File: rtl/if_stage.sv
// P7 fetch stage: PC register, next-PC selection, AdEL detection and IF/ID register.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET  = PC_RESET_DEF,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
  parameter logic [31:0] IM_BASE   = IM_BASE_DEF,
  parameter logic [31:0] IM_LIMIT  = IM_LIMIT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        intreq,
  input  logic        jump_d,
  input  logic        eret_d,
  input  logic [31:0] npc,
  input  logic [31:0] im_rdata,
  output logic [31:0] im_addr,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic [4:0]  exc_d,
  output logic        bd_d
);

  logic        adel_f;
  logic [31:0] pc_next;
  logic [31:0] bubble_pc;
  logic [31:0] bubble_pc8;
  logic        bd_in;
  ifid_ctrl_e  ctrl;

  assign adel_f  = fetch_addr_err(pc_f, IM_BASE, IM_LIMIT);
  assign im_addr = pc_f;

  // Next-PC and IF/ID control: intreq > stall > eret > jump > sequential.
  always_comb begin
    pc_next    = pc_f + 32'd4;
    ctrl       = IFID_LOAD;
    bubble_pc  = 32'h0000_0000;
    bubble_pc8 = 32'h0000_0000;
    bd_in      = 1'b0;
    if (intreq) begin
      pc_next = EXC_ENTRY;
      ctrl    = IFID_BUBBLE;
    end else if (stall) begin
      pc_next = pc_f;
      ctrl    = IFID_HOLD;
    end else if (eret_d) begin
      pc_next    = npc;
      ctrl       = IFID_BUBBLE;
      bubble_pc  = npc;
      bubble_pc8 = npc + 32'd8;
    end else if (jump_d) begin
      pc_next = npc;
      bd_in   = 1'b1;
    end else begin
      pc_next = pc_f + 32'd4;
    end
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f <= PC_RESET;
    end else begin
      pc_f <= pc_next;
    end
  end

  if_id_reg u_if_id_reg (
    .clk        (clk),
    .reset      (reset),
    .ctrl       (ctrl),
    .instr_in   (adel_f ? 32'h0000_0000 : im_rdata),
    .pc_in      (pc_f),
    .pc8_in     (pc_f + 32'd8),
    .exc_in     (adel_f ? EXC_ADEL : EXC_NONE),
    .bd_in      (bd_in),
    .bubble_pc  (bubble_pc),
    .bubble_pc8 (bubble_pc8),
    .instr_d    (instr_d),
    .pc_d       (pc_d),
    .pc8_d      (pc8_d),
    .exc_d      (exc_d),
    .bd_d       (bd_d)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage with a simple address-encoding memory.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset, stall, intreq, jump_d, eret_d;
  logic [31:0] npc;
  logic [31:0] im_rdata;
  logic [31:0] im_addr, pc_f, instr_d, pc_d, pc8_d;
  logic [4:0]  exc_d;
  logic        bd_d;
  logic        enc_mem;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  // Constant word first, then a word that encodes its own address low half.
  assign im_rdata = enc_mem ? {16'h2408, im_addr[15:0]} : 32'h2408_0001;

  if_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .intreq(intreq),
    .jump_d(jump_d), .eret_d(eret_d), .npc(npc), .im_rdata(im_rdata),
    .im_addr(im_addr), .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d),
    .pc8_d(pc8_d), .exc_d(exc_d), .bd_d(bd_d)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] i, input logic [31:0] p,
                            input logic [31:0] p8, input logic [4:0] e, input logic b);
    check({tag, ".instr"}, instr_d, i);
    check({tag, ".pc_d"},  pc_d,    p);
    check({tag, ".pc8_d"}, pc8_d,   p8);
    check({tag, ".exc"},   {27'd0, exc_d}, {27'd0, e});
    check({tag, ".bd"},    {31'd0, bd_d},  {31'd0, b});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; intreq = 1'b0; jump_d = 1'b0; eret_d = 1'b0;
    npc = 32'h0; enc_mem = 1'b0;
    step(); step();
    check("rst.pc", pc_f, 32'h0000_3000);
    check_ifid("rst", 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);

    reset = 1'b0;
    step(); check("seq.pc1", pc_f, 32'h0000_3004);
    step(); check("seq.pc2", pc_f, 32'h0000_3008);
    step(); check("seq.pc3", pc_f, 32'h0000_300C);
    check("seq.im_addr", im_addr, 32'h0000_300C);
    check_ifid("seq", 32'h2408_0001, 32'h0000_3008, 32'h0000_3010, 5'd0, 1'b0);

    step(); check("pre_jump.pc", pc_f, 32'h0000_3010);
    jump_d = 1'b1; npc = 32'h0000_3400;
    step(); check("jump.pc", pc_f, 32'h0000_3400);
    check_ifid("jump", 32'h2408_0001, 32'h0000_3010, 32'h0000_3018, 5'd0, 1'b1);
    jump_d = 1'b0; enc_mem = 1'b1;
    step(); check("after_jump.pc", pc_f, 32'h0000_3404);
    check_ifid("after_jump", 32'h2408_3400, 32'h0000_3400, 32'h0000_3408, 5'd0, 1'b0);

    jump_d = 1'b1; npc = 32'h0000_3020;
    step(); check("to3020.pc", pc_f, 32'h0000_3020);
    jump_d = 1'b0; stall = 1'b1;
    step(); check("stall1.pc", pc_f, 32'h0000_3020);
    check_ifid("stall1", 32'h2408_3404, 32'h0000_3404, 32'h0000_340C, 5'd0, 1'b1);
    eret_d = 1'b1; npc = 32'h0000_3100;
    step(); check("stall2.pc", pc_f, 32'h0000_3020);
    check_ifid("stall2", 32'h2408_3404, 32'h0000_3404, 32'h0000_340C, 5'd0, 1'b1);
    eret_d = 1'b0; stall = 1'b0;
    step(); check("unstall.pc", pc_f, 32'h0000_3024);
    check_ifid("unstall", 32'h2408_3020, 32'h0000_3020, 32'h0000_3028, 5'd0, 1'b0);

    jump_d = 1'b1; npc = 32'h0000_3050;
    step(); check("to3050.pc", pc_f, 32'h0000_3050);
    jump_d = 1'b0; intreq = 1'b1; stall = 1'b1;
    step(); check("int.pc", pc_f, 32'h0000_4180);
    check_ifid("int", 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    intreq = 1'b0; stall = 1'b0;

    eret_d = 1'b1; jump_d = 1'b1; npc = 32'h0000_3100;
    step(); check("eret.pc", pc_f, 32'h0000_3100);
    check_ifid("eret", 32'h0, 32'h0000_3100, 32'h0000_3108, 5'd0, 1'b0);
    eret_d = 1'b0; jump_d = 1'b0;
    step(); check("after_eret.pc", pc_f, 32'h0000_3104);
    check_ifid("after_eret", 32'h2408_3100, 32'h0000_3100, 32'h0000_3108, 5'd0, 1'b0);

    jump_d = 1'b1; npc = 32'h0000_3002;
    step(); jump_d = 1'b0;
    step(); check("mis.pc", pc_f, 32'h0000_3006);
    check_ifid("mis", 32'h0, 32'h0000_3002, 32'h0000_300A, 5'd4, 1'b0);

    jump_d = 1'b1; npc = 32'h0000_7000;
    step(); jump_d = 1'b0;
    step(); check("hi.pc", pc_f, 32'h0000_7004);
    check_ifid("hi", 32'h0, 32'h0000_7000, 32'h0000_7008, 5'd4, 1'b0);

    jump_d = 1'b1; npc = 32'h0000_6FFC;
    step(); jump_d = 1'b0;
    step(); check("limit.pc", pc_f, 32'h0000_7000);
    check_ifid("limit", 32'h2408_6FFC, 32'h0000_6FFC, 32'h0000_7004, 5'd0, 1'b0);

    jump_d = 1'b1; npc = 32'h0000_2FFC;
    step(); jump_d = 1'b0;
    step(); check_ifid("below", 32'h0, 32'h0000_2FFC, 32'h0000_3004, 5'd4, 1'b0);

    jump_d = 1'b1; npc = 32'hFFFF_FFFC;
    step(); jump_d = 1'b0;
    step(); check("wrap.pc", pc_f, 32'h0000_0000);
    check_ifid("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0000_0004, 5'd4, 1'b0);

    reset = 1'b1; intreq = 1'b1; stall = 1'b1;
    step(); check("rst2.pc", pc_f, 32'h0000_3000);
    check_ifid("rst2", 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Fetch stage of the P7 pipelined MIPS core.
- Holds the program counter and drives the instruction-memory address.
- Detects fetch-address exceptions (AdEL) and registers the fetched instruction into the IF/ID pipeline register.
- Consumes the next-PC value computed in D by npc, and produces instr_d/pc8_d that npc and the D-stage decoder consume.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset.
- EXC_ENTRY, 32'h0000_4180, exception/interrupt handler entry.
- IM_BASE, 32'h0000_3000, lowest legal fetch address.
- IM_LIMIT, 32'h0000_6FFC, highest legal fetch address (inclusive).

Ports:
- clk  in  1  system clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  hazard unit: hold PC and IF/ID.
- intreq  in  1  CP0 exception/interrupt taken: flush and redirect.
- jump_d  in  1  D-stage instr is branch/jump/jr/jalr; npc is valid.
- eret_d  in  1  D-stage instr is eret; npc holds epc.
- npc  in  32  next-PC from npc block.
- im_rdata  in  32  combinational instruction-memory read data.
- im_addr  out  32  equals pc_f.
- pc_f  out  32  current fetch PC.
- instr_d  out  32  IF/ID instruction.
- pc_d  out  32  IF/ID PC (EPC source).
- pc8_d  out  32  IF/ID PC+8 (to npc, link value).
- exc_d  out  5  IF/ID exception code, 0 = none.
- bd_d  out  1  IF/ID instruction is in a branch delay slot.

Behaviour:
- adel_f (comb) = pc_f[1:0]!=0 OR pc_f<IM_BASE OR pc_f>IM_LIMIT, unsigned compare.
- Reset, synchronous, evaluated first:
  - pc_f=PC_RESET.
  - instr_d=0, pc_d=0, pc8_d=0, exc_d=0, bd_d=0.
- Update priority each rising edge: reset > intreq > stall > eret_d > jump_d > sequential.
- intreq:
  - pc_f<=EXC_ENTRY.
  - IF/ID loads bubble: instr 0, pc_d 0, pc8_d 0, exc 0, bd 0.
  - Overrides stall.
- stall (no intreq): pc_f and all IF/ID outputs hold. im_addr keeps presenting pc_f.
- eret_d (no stall):
  - pc_f<=npc.
  - IF/ID loads bubble with pc_d<=npc and pc8_d<=npc+8, so an interrupt landing on the bubble has a valid EPC.
  - eret has no delay slot.
- jump_d (no stall, no eret_d):
  - pc_f<=npc.
  - IF/ID loads the delay-slot instr from pc_f with bd_d<=1.
- Sequential: pc_f<=pc_f+4 (mod 2^32, wraps 0xFFFF_FFFC->0); bd_d<=0.
- IF/ID normal load:
  - instr_d<=adel_f?0:im_rdata.
  - pc_d<=pc_f; pc8_d<=pc_f+8 (mod 2^32).
  - exc_d<=adel_f?5'd4:0.
- Fetch latency:
  - im_rdata is combinational on im_addr.
  - An instr at address A appears on instr_d one edge after pc_f==A with no stall.
- Misaligned or out-of-range pc_f:
  - No memory data is forwarded.
  - The AdEL NOP travels down the pipe; pc_f still advances normally until intreq arrives.
- Reset asserted mid-stall or with intreq: reset wins.

Decomposition:
- head.v: `PC_RESET, `EXC_ENTRY, `EXC_ADEL (5'd4), `EXC_NONE.
- One sub-module: if_id_reg. It covers the IF/ID register with load/hold/bubble controls and a bubble-pc value input.
- PC register and next-PC mux stay in if_stage.

Test Plan:
- Reset, then 3 cycles with no stall/jump, im_rdata=0x2408_0001:
  - pc_f reads 0x3000, 0x3004, 0x3008, 0x300C.
  - instr_d=0x2408_0001, pc_d=0x3008, pc8_d=0x3010, bd_d=0.
- jump_d=1 with npc=0x3400 while pc_f=0x3010:
  - Next pc_f=0x3400.
  - pc_d=0x3010 with bd_d=1; the following cycle pc_d=0x3400 with bd_d=0.
- stall=1 for 2 cycles at pc_f=0x3020: pc_f and instr_d/pc_d unchanged; on release pc_f=0x3024.
- intreq=1 together with stall=1 at pc_f=0x3050: pc_f=0x4180 and instr_d=0, pc_d=0, exc_d=0, bd_d=0.
- eret_d=1 with npc=0x3100: pc_f=0x3100; instr_d=0, pc_d=0x3100, pc8_d=0x3108.
- Fetch with pc_f=0x3002, and separately with pc_f=0x7000:
  - exc_d=4, instr_d=0 in both cases.
  - pc_d=0x3002 and 0x7000 respectively.
